// File: rtl/pipe_pkg.sv
// Shared widths, control-bit indices and EX/MEM payload layout for pipeline-stage buffers.
package pipe_pkg;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 106;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  localparam int CTL_MEMREAD  = 0;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_MEMTOREG = 2;
  localparam int CTL_REGWRITE = 3;

  localparam int EXMEM_ALU_MSB = 68;
  localparam int EXMEM_ALU_LSB = 37;
  localparam int EXMEM_RD2_MSB = 36;
  localparam int EXMEM_RD2_LSB = 5;
  localparam int EXMEM_WR_MSB  = 4;
  localparam int EXMEM_WR_LSB  = 0;

  // Field order matches the bit offsets above, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rd2;
    logic [4:0]  write_reg;
  } exmem_data_t;

  function automatic logic [EXMEM_DATA_W-1:0] pack_exmem(input logic [31:0] alu_result,
                                                         input logic [31:0] rd2,
                                                         input logic [4:0]  write_reg);
    exmem_data_t d;
    d.alu_result = alu_result;
    d.rd2        = rd2;
    d.write_reg  = write_reg;
    return d;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry (valid + ctrl + data); load wins over clear, single-cycle update.
// Clear drops only the valid bit so the data flops keep toggling to a minimum.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: 1-cycle latency, 1 beat/cycle; SKID=1 gives a flop-sourced
// in_ready via a second entry, SKID=0 a single entry with in_ready = ~out_valid | out_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              accept;
  logic              drain;
  logic              m_free;
  logic              m_load;
  logic              m_clear;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_d_ctrl;
  logic [DATA_W-1:0] m_d_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready;
  assign m_free = ~m_valid | drain;

  // A held skid entry is always older than the incoming beat, so it refills M first.
  assign m_load   = ~flush & m_free & (s_valid | accept);
  assign m_clear  = flush | drain;
  assign m_d_ctrl = s_valid ? s_ctrl : in_ctrl;
  assign m_d_data = s_valid ? s_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
    .clk    (clk),
    .reset  (reset),
    .load   (m_load),
    .clear  (m_clear),
    .d_ctrl (m_d_ctrl),
    .d_data (m_d_data),
    .valid  (m_valid),
    .ctrl   (m_ctrl),
    .data   (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_load;
      logic s_clear;

      assign s_load  = ~flush & accept & (s_valid | ~m_free);
      assign s_clear = flush | (m_free & s_valid);

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s (
        .clk    (clk),
        .reset  (reset),
        .load   (s_load),
        .clear  (s_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (s_valid),
        .ctrl   (s_ctrl),
        .data   (s_data)
      );

      assign in_ready = ~s_valid;
    end else begin : g_no_skid
      assign s_valid  = 1'b0;
      assign s_ctrl   = '0;
      assign s_data   = '0;
      assign in_ready = ~m_valid | out_ready;
    end
  endgenerate

  // Bubbles must never carry live control bits (RegWrite/MemWrite).
  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule
